// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: segment encodings, send order and state set shared by tx_segment_scheduler
package tx_sched_pkg;

    localparam int NSEG = 5;

    localparam logic [4:0] SEG_KEY   = 5'b00001;
    localparam logic [4:0] SEG_PT    = 5'b00010;
    localparam logic [4:0] SEG_CT    = 5'b00100;
    localparam logic [4:0] SEG_TRACE = 5'b01000;
    localparam logic [4:0] SEG_PARAM = 5'b10000;

    localparam logic [2:0] IDX_PARAM = 3'd0;
    localparam logic [2:0] IDX_PT    = 3'd1;
    localparam logic [2:0] IDX_KEY   = 3'd2;
    localparam logic [2:0] IDX_CT    = 3'd3;
    localparam logic [2:0] IDX_TRACE = 3'd4;
    localparam logic [2:0] IDX_NONE  = 3'd7;

    localparam logic [NSEG-1:0][4:0] SEG_ORDER = {SEG_TRACE, SEG_CT, SEG_KEY, SEG_PT, SEG_PARAM};

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_GAP, S_FINISH} sched_state_e;

    function automatic logic [4:0] seg_onehot(input logic [2:0] idx);
        return idx == IDX_PARAM ? SEG_PARAM :
               idx == IDX_PT    ? SEG_PT    :
               idx == IDX_KEY   ? SEG_KEY   :
               idx == IDX_CT    ? SEG_CT    :
               idx == IDX_TRACE ? SEG_TRACE : 5'b0;
    endfunction

    function automatic logic [2:0] first_idx(input logic [4:0] m);
        first_idx = IDX_NONE;
        for (int i = NSEG - 1; i >= 0; i--)
            if ((m & SEG_ORDER[3'(i)]) != 5'b0) first_idx = 3'(i);
    endfunction

endpackage

// File: rtl/tx_segment_scheduler_counter.sv
// sched_down_counter: loadable down-counter that holds at zero and flags it
module sched_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && !zero)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tx_segment_scheduler.sv
// tx_segment_scheduler: sends PARAM,PT,KEY,CT,TRACE through the sender handshake; TX_SCHED_WATCHDOG_EN adds a send timeout
module tx_segment_scheduler
    import tx_sched_pkg::*;
#(
    parameter int GAP_W       = 16,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TO_W        = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       seg_mask,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic [4:0]       transmit_sel,
    output logic             transmit_en,
    input  logic             transmit_done,
    output logic             param_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       cur_seg
);

    sched_state_e     state;
    logic [4:0]       pend;
    logic [4:0]       pend_src;
    logic [4:0]       nxt_bit;
    logic [2:0]       nxt_idx;
    logic [GAP_W-1:0] gap_q;
    logic             gap_zero;
    logic             seg_done;
    logic             to_gap;
    logic             do_issue;
    logic             wd_expired;

    if (64'(TIMEOUT_CYC) >= (64'd1 << TO_W)) begin : g_to_w_check
        $error("TO_W too narrow for TIMEOUT_CYC");
    end

    assign pend_src = (state == S_IDLE) ? seg_mask : pend;
    assign nxt_idx  = first_idx(pend_src);
    assign nxt_bit  = seg_onehot(nxt_idx);
    assign seg_done = (state == S_WAIT_DONE) && transmit_done;
    assign to_gap   = seg_done && (pend != 5'b0) && (gap_q != '0);
    assign do_issue = (state == S_IDLE && start && seg_mask != 5'b0) ||
                      (seg_done && pend != 5'b0 && gap_q == '0) ||
                      (state == S_GAP && gap_zero);

    sched_down_counter #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .load     (to_gap),
        .en       (state == S_GAP),
        .load_val (gap_q - 1'b1),
        .zero     (gap_zero)
    );

`ifdef TX_SCHED_WATCHDOG_EN
    logic wd_zero;

    sched_down_counter #(.W(TO_W)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .load     (do_issue),
        .en       (state == S_ISSUE || state == S_WAIT_DONE),
        .load_val (TO_W'(TIMEOUT_CYC)),
        .zero     (wd_zero)
    );

    assign wd_expired = (state == S_WAIT_DONE) && !transmit_done && wd_zero;
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pend         <= 5'b0;
            gap_q        <= '0;
            transmit_sel <= 5'b0;
            transmit_en  <= 1'b0;
            param_sel    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            cur_seg      <= IDX_NONE;
        end else begin
            transmit_en  <= 1'b0;
            transmit_sel <= 5'b0;
            done         <= 1'b0;
            param_sel    <= (state == S_ISSUE || state == S_WAIT_DONE) && cur_seg == IDX_PARAM;
            case (state)
                S_IDLE: if (start) begin
                    pend  <= seg_mask;
                    gap_q <= gap_cycles;
                    busy  <= 1'b1;
                    err   <= 1'b0;
                    state <= S_FINISH;
                end
                S_ISSUE: state <= S_WAIT_DONE;
                S_WAIT_DONE: if (seg_done || wd_expired) begin
                    state <= to_gap ? S_GAP : S_FINISH;
                    if (wd_expired) err <= 1'b1;
                end
                S_FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    cur_seg <= IDX_NONE;
                    state   <= S_IDLE;
                end
                default: ;
            endcase
            if (do_issue) begin
                state        <= S_ISSUE;
                transmit_en  <= 1'b1;
                transmit_sel <= nxt_bit;
                cur_seg      <= nxt_idx;
                pend         <= pend_src & ~nxt_bit;
                param_sel    <= nxt_idx == IDX_PARAM;
            end
        end
    end

endmodule

// File: tb/tb_tx_segment_scheduler.sv
// tb_tx_segment_scheduler: scoreboard bench for tx_segment_scheduler; watchdog scenario runs when TX_SCHED_WATCHDOG_EN is defined
`timescale 1ns/1ps
module tb_tx_segment_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  seg_mask = 5'b0;
    logic [15:0] gap_cycles = 16'd0;
    logic [4:0]  transmit_sel;
    logic        transmit_en;
    logic        transmit_done;
    logic        param_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  cur_seg;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;

    int total = 0, bad = 0, cyc = 0;
    int resp_cyc = 10, resp_left = -1, pend_resp = 0, gap_exp = 0;
    int en_cnt = 0, done_cnt = 0, ps_cnt = 0, last_done = 0, done_cyc = -1, last_en_cyc = 0, start_cyc = 0;
    bit have_done = 0, first_en = 1;
    logic [4:0] exp_sel;
    logic [4:0] exp_q[$];
    logic [4:0] order [5] = '{5'b10000, 5'b00010, 5'b00001, 5'b00100, 5'b01000};

    assign transmit_done = model_done | spur_done;

    tx_segment_scheduler #(
        .GAP_W       (16),
        .TIMEOUT_CYC (100),
        .TO_W        (22)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seg_mask      (seg_mask),
        .gap_cycles    (gap_cycles),
        .transmit_sel  (transmit_sel),
        .transmit_en   (transmit_en),
        .transmit_done (transmit_done),
        .param_sel     (param_sel),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .cur_seg       (cur_seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sender model: one done pulse resp_cyc-1 cycles after each launch, while resp_left allows
    initial forever begin
        @(posedge clk); #1;
        model_done = 1'b0;
        if (rst) pend_resp = 0;
        else if (pend_resp > 0) begin
            pend_resp--;
            if (pend_resp == 0) model_done = 1'b1;
        end else if (transmit_en && resp_left != 0) begin
            if (resp_left > 0) resp_left--;
            pend_resp = resp_cyc - 1;
        end
    end

    initial forever begin
        @(posedge clk); #2;
        if (rst) have_done = 0;
        if (transmit_en) begin
            en_cnt++;
            last_en_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sel_order: got sel=%b, required no launch", transmit_sel);
            end else begin
                exp_sel = exp_q.pop_front();
                if (transmit_sel !== exp_sel) begin
                    bad++;
                    $display("FAIL sel_order: got sel=%b, required %b", transmit_sel, exp_sel);
                end
            end
            if (!first_en) begin
                total++;
                if (!have_done) begin
                    bad++;
                    $display("FAIL launch_before_done: got launch at cycle %0d, required a sender done first", cyc);
                end else if (cyc - last_done != gap_exp + 1) begin
                    bad++;
                    $display("FAIL gap_timing: got %0d cycles done->en, required %0d", cyc - last_done, gap_exp + 1);
                end
            end
            first_en = 0;
            have_done = 0;
        end
        if (model_done) begin
            last_done = cyc;
            have_done = 1;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (param_sel) ps_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic launch(input logic [4:0] mask, input int gap, input int resp, input int nexp);
        int n = 0;
        for (int i = 0; i < 5; i++)
            if ((mask & order[i]) != 5'b0 && n < nexp) begin
                exp_q.push_back(order[i]);
                n++;
            end
        gap_exp = gap; resp_cyc = resp;
        en_cnt = 0; done_cnt = 0; ps_cnt = 0; done_cyc = -1; first_en = 1;
        seg_mask = mask; gap_cycles = 16'(gap); start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit got);
        for (int t = 0; t < lim && !done; t++) @(negedge clk);
        got = done;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({transmit_sel, transmit_en, param_sel, busy, done, err, cur_seg} !== {5'b0, 5'b0, 3'd7}) begin
            bad++;
            $display("FAIL reset_state: got %b, required %b",
                     {transmit_sel, transmit_en, param_sel, busy, done, err, cur_seg}, {5'b0, 5'b0, 3'd7});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full();
        bit got;
        launch(5'b11111, 200, 50, 5);
        total++;
        if ({busy, transmit_en, transmit_sel} !== {2'b11, 5'b10000}) begin
            bad++;
            $display("FAIL full_first_launch: got %b, required %b", {busy, transmit_en, transmit_sel}, {2'b11, 5'b10000});
        end
        wait_done(3000, got);
        total++;
        if (!got) begin bad++; $display("FAIL full_done: got no done, required done within 3000 cycles"); end
        total++;
        if (en_cnt != 5 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_launches: got %0d launches (%0d unmatched), required 5", en_cnt, exp_q.size());
        end
        total++;
        if (done_cnt != 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL full_done_err: got done_cnt=%0d err=%b, required 1 and 0", done_cnt, err);
        end
        total++;
        if (ps_cnt != 51) begin bad++; $display("FAIL full_param_sel: got %0d high cycles, required 51", ps_cnt); end
        total++;
        if ({busy, cur_seg} !== {1'b0, 3'd7}) begin
            bad++;
            $display("FAIL full_idle: got busy=%b cur_seg=%0d, required 0 and 7", busy, cur_seg);
        end
        exp_q.delete();
    endtask

    task automatic test_sparse();
        bit got;
        launch(5'b01100, 0, 6, 5);
        total++;
        if ({busy, transmit_en, transmit_sel} !== {2'b11, 5'b00100}) begin
            bad++;
            $display("FAIL sparse_first_launch: got %b, required %b", {busy, transmit_en, transmit_sel}, {2'b11, 5'b00100});
        end
        wait_done(200, got);
        total++;
        if (!got || en_cnt != 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL sparse_launches: got done=%b launches=%0d, required 1 and 2", got, en_cnt);
        end
        total++;
        if (ps_cnt != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL sparse_param_done: got param_sel cycles=%0d done_cnt=%0d, required 0 and 1", ps_cnt, done_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_empty();
        bit got;
        launch(5'b00000, 0, 5, 5);
        wait_done(20, got);
        total++;
        if (!got || done_cyc - start_cyc != 2) begin
            bad++;
            $display("FAIL empty_done_latency: got done=%b latency=%0d, required 1 and 2", got, done_cyc - start_cyc);
        end
        total++;
        if (en_cnt != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL empty_launches: got launches=%0d done_cnt=%0d, required 0 and 1", en_cnt, done_cnt);
        end
    endtask

    task automatic test_spurious();
        bit got;
        en_cnt = 0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || en_cnt != 0 || cur_seg !== 3'd7) begin
            bad++;
            $display("FAIL idle_spurious: got busy=%b launches=%0d cur_seg=%0d, required 0, 0, 7", busy, en_cnt, cur_seg);
        end
        fork
            begin
                launch(5'b00111, 10, 8, 5);
                wait_done(1000, got);
            end
            begin
                @(negedge clk);
                spur_done = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
                start = 1'b1;
                seg_mask = 5'b11111;
                @(negedge clk);
                start = 1'b0;
                for (int t = 0; t < 200 && !model_done; t++) @(negedge clk);
                repeat (4) @(negedge clk);
                spur_done = 1'b1;
                start = 1'b1;
                @(negedge clk);
                spur_done = 1'b0;
                start = 1'b0;
            end
        join
        total++;
        if (!got || en_cnt != 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL spurious_launches: got done=%b launches=%0d, required 1 and 3", got, en_cnt);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL spurious_done_cnt: got %0d, required 1", done_cnt); end
        exp_q.delete();
    endtask

    task automatic test_reset_gap();
        bit got;
        launch(5'b00011, 50, 5, 1);
        for (int t = 0; t < 100 && !model_done; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({transmit_sel, transmit_en, param_sel, busy, done, err, cur_seg} !== {5'b0, 5'b0, 3'd7}) begin
            bad++;
            $display("FAIL gap_reset_state: got %b, required %b",
                     {transmit_sel, transmit_en, param_sel, busy, done, err, cur_seg}, {5'b0, 5'b0, 3'd7});
        end
        rst = 1'b0;
        repeat (80) @(negedge clk);
        total++;
        if (en_cnt != 1 || done_cnt != 0) begin
            bad++;
            $display("FAIL gap_reset_quiet: got launches=%0d done_cnt=%0d, required 1 and 0", en_cnt, done_cnt);
        end
        exp_q.delete();
        launch(5'b10001, 3, 4, 5);
        wait_done(200, got);
        total++;
        if (!got || en_cnt != 2 || done_cnt != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL post_reset_run: got done=%b launches=%0d done_cnt=%0d, required 1, 2, 1", got, en_cnt, done_cnt);
        end
        exp_q.delete();
    endtask

`ifdef TX_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        bit got;
        resp_left = 1;
        launch(5'b11111, 0, 10, 2);
        wait_done(400, got);
        total++;
        if (!got || err !== 1'b1) begin
            bad++;
            $display("FAIL wd_err: got done=%b err=%b, required 1 and 1", got, err);
        end
        total++;
        if (done_cyc - last_en_cyc != 102) begin
            bad++;
            $display("FAIL wd_timing: got done %0d cycles after PT launch, required 102", done_cyc - last_en_cyc);
        end
        total++;
        if (en_cnt != 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL wd_dropped: got launches=%0d, required 2", en_cnt);
        end
        resp_left = -1;
        launch(5'b00001, 0, 5, 5);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL wd_err_clear: got err=%b, required 0", err); end
        wait_done(100, got);
        total++;
        if (!got || done_cnt != 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL wd_recover: got done=%b done_cnt=%0d err=%b, required 1, 1, 0", got, done_cnt, err);
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_full();
        test_sparse();
        test_empty();
        test_spurious();
        test_reset_gap();
`ifdef TX_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
